serial_adder: RTL and testbench

- Parametrised, multi-cycle successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, through one DIGIT-bit adder slice and a registered carry.
- Uses a start/busy/done handshake. Intended for datapaths where area matters more than latency.
- Also reports unsigned carry-out and signed (two's-complement) overflow.

---
 rtl/serial_adder_if.sv | 16 +
 rtl/serial_adder.sv | 109 ++++++++++
 tb/tb_serial_adder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake bundle for the serial adder.
// Operands and carry-in flow to the adder. Status and results flow back.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, s, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, s, cout, ovf);
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a + b + cin through one DIGIT-bit slice, N = WIDTH/DIGIT cycles.
// Reports the unsigned carry-out and the two's-complement overflow.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation are held
// RUN   | one DIGIT slice added per edge, N edges in total
// DONE  | one-cycle done pulse; a new start here is accepted back-to-back
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sign_a;
  logic             sign_b;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    slice = {1'b0, acc[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  end

  // Operand A shifts out of the bottom while sum digits enter from the top,
  // so after N steps the same register holds the finished sum.
  if (N == 1) begin : g_single
    assign acc_next = slice[DIGIT-1:0];
  end else begin : g_multi
    assign acc_next = {slice[DIGIT-1:0], acc[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            acc    <= bus.a;
            op_b   <= bus.b;
            carry  <= bus.cin;
            sign_a <= bus.a[WIDTH-1];
            sign_b <= bus.b[WIDTH-1];
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          op_b  <= op_b >> DIGIT;
          carry <= slice[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            s_q    <= acc_next;
            cout_q <= slice[DIGIT];
            ovf_q  <= (sign_a == sign_b) && (acc_next[WIDTH-1] != sign_a);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (4/1, 8/4, 8/1) with a per-instance
// expected-result queue that is popped whenever done pulses.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst4, rst8q, rst8;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(4)) bus4 ();
  serial_adder_if #(.WIDTH(8)) bus8q ();
  serial_adder_if #(.WIDTH(8)) bus8 ();

  serial_adder #(.WIDTH(4), .DIGIT(1)) u_add4  (.clk(clk), .rst_n(rst4),  .bus(bus4));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_add8q (.clk(clk), .rst_n(rst8q), .bus(bus8q));
  serial_adder #(.WIDTH(8), .DIGIT(1)) u_add8  (.clk(clk), .rst_n(rst8),  .bus(bus8));

  logic [9:0] q4[$];
  logic [9:0] q8q[$];
  logic [9:0] q8[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result packed as {cout, ovf, s[7:0]}
  function automatic logic [9:0] model(input int w, input int a, input int b, input int c);
    int   full, sv;
    logic co, ov, sa, sb, ss;
    full = a + b + c;
    sv   = full & ((1 << w) - 1);
    co   = ((full >> w) & 1) != 0;
    sa   = ((a >> (w - 1)) & 1) != 0;
    sb   = ((b >> (w - 1)) & 1) != 0;
    ss   = ((sv >> (w - 1)) & 1) != 0;
    ov   = (sa == sb) && (ss != sa);
    return {co, ov, 8'(sv)};
  endfunction

  task automatic go4(input int a, input int b, input int c);
    bus4.start = 1'b1; bus4.a = 4'(a); bus4.b = 4'(b); bus4.cin = c[0];
    q4.push_back(model(4, a, b, c));
  endtask

  task automatic go8q(input int a, input int b, input int c);
    bus8q.start = 1'b1; bus8q.a = 8'(a); bus8q.b = 8'(b); bus8q.cin = c[0];
    q8q.push_back(model(8, a, b, c));
  endtask

  task automatic go8(input int a, input int b, input int c);
    bus8.start = 1'b1; bus8.a = 8'(a); bus8.b = 8'(b); bus8.cin = c[0];
    q8.push_back(model(8, a, b, c));
  endtask

  task automatic drain();
    int n = 0;
    while ((q4.size() + q8q.size() + q8.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 300), 1);
  endtask

  // Scoreboard monitors
  int   cyc4 = 0;
  int   last_done4 = -1;
  bit   gap_mode = 1'b0;
  logic prev4 = 1'b0, prev8q = 1'b0, prev8 = 1'b0;

  always @(negedge clk) begin
    cyc4++;
    if (bus4.done) begin
      check("u4_pending", 32'(q4.size() > 0), 1);
      if (q4.size() > 0) check("u4_result", 32'({bus4.cout, bus4.ovf, 4'b0, bus4.s}), 32'(q4.pop_front()));
      check("u4_done_twice", 32'(prev4), 0);
      if (gap_mode && last_done4 >= 0) check("u4_done_gap", 32'(cyc4 - last_done4), 5);
      last_done4 = cyc4;
    end
    prev4 = bus4.done;
  end

  always @(negedge clk) begin
    if (bus8q.done) begin
      check("u8q_pending", 32'(q8q.size() > 0), 1);
      if (q8q.size() > 0) check("u8q_result", 32'({bus8q.cout, bus8q.ovf, bus8q.s}), 32'(q8q.pop_front()));
      check("u8q_done_twice", 32'(prev8q), 0);
    end
    prev8q = bus8q.done;
  end

  always @(negedge clk) begin
    if (bus8.done) begin
      check("u8_pending", 32'(q8.size() > 0), 1);
      if (q8.size() > 0) check("u8_result", 32'({bus8.cout, bus8.ovf, bus8.s}), 32'(q8.pop_front()));
      check("u8_done_twice", 32'(prev8), 0);
    end
    prev8 = bus8.done;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst4 = 1'b0; rst8q = 1'b0; rst8 = 1'b0;
    bus4.start = 1'b0;  bus4.a = '0;  bus4.b = '0;  bus4.cin = 1'b0;
    bus8q.start = 1'b0; bus8q.a = '0; bus8q.b = '0; bus8q.cin = 1'b0;
    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus4.busy), 0);
    check("rst_done", 32'(bus4.done), 0);
    check("rst_s", 32'(bus4.s), 0);
    check("rst_cout_ovf", 32'({bus4.cout, bus4.ovf}), 0);
    check("rst8_outs", 32'({bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.s}), 0);
    rst4 = 1'b1; rst8q = 1'b1; rst8 = 1'b1;
    @(negedge clk);

    // Latency: 0+0+1 on WIDTH=4, DIGIT=1
    go4(0, 0, 1);
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus4.start = 1'b0;
      check("t1_busy", 32'(bus4.busy), 1);
      check("t1_nodone", 32'(bus4.done), 0);
    end
    @(negedge clk);
    check("t1_done", 32'(bus4.done), 1);
    check("t1_busy_low", 32'(bus4.busy), 0);
    drain();

    // Wrap and overflow, with output hold
    repeat (2) @(negedge clk);
    go4(15, 1, 0);
    @(negedge clk);
    bus4.start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("t2_hold_idle", 32'({bus4.cout, bus4.ovf, bus4.s}), 32'(6'b10_0000));
    go4(7, 1, 0);
    @(negedge clk);
    bus4.start = 1'b0;
    check("t2_busy", 32'(bus4.busy), 1);
    check("t2_hold_run", 32'({bus4.cout, bus4.ovf, bus4.s}), 32'(6'b10_0000));
    drain();
    repeat (2) @(negedge clk);
    check("t2_hold_after", 32'({bus4.cout, bus4.ovf, bus4.s}), 32'(6'b01_1000));

    // Exhaustive back-to-back with start held high
    gap_mode = 1'b1;
    last_done4 = -1;
    for (int i = 0; i < 512; i++) begin
      if (i > 0) @(negedge clk);
      go4((i >> 5) & 15, (i >> 1) & 15, i & 1);
      if (i == 0) @(posedge clk);
      else repeat (5) @(posedge clk);
    end
    @(negedge clk);
    bus4.start = 1'b0;
    drain();
    gap_mode = 1'b0;

    // WIDTH=8, DIGIT=4
    go8q(255, 255, 1);
    @(posedge clk);
    @(negedge clk);
    bus8q.start = 1'b0;
    check("t4_busy1", 32'(bus8q.busy), 1);
    @(negedge clk);
    check("t4_busy2", 32'({bus8q.busy, bus8q.done}), 32'(2'b10));
    @(negedge clk);
    check("t4_done", 32'({bus8q.busy, bus8q.done}), 32'(2'b01));
    drain();
    go8q(128, 128, 0);
    @(negedge clk);
    bus8q.start = 1'b0;
    drain();

    // WIDTH=8, DIGIT=1: start while busy is ignored
    go8(8'h35, 8'h4A, 0);
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    drain();
    repeat (12) @(negedge clk);
    check("t5_result_held", 32'(bus8.s), 32'(8'h7F));

    // Reset mid-run: no done may follow
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_busy_pre_rst", 32'(bus8.busy), 1);
    rst8 = 1'b0;
    @(negedge clk);
    check("t5_rst_outs", 32'({bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.s}), 0);
    rst8 = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_idle_after_rst", 32'(bus8.busy), 0);
    go8(8'h7F, 8'h01, 0);
    @(negedge clk);
    bus8.start = 1'b0;
    drain();
    check("t5_final", 32'({bus8.cout, bus8.ovf, bus8.s}), 32'(10'b01_1000_0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
